// File: rtl/insertion_sort_stream.sv
// Streaming insertion sorter: fills a sorted register array one element per cycle,
// then drains it in order over a valid/ready output.
module insertion_sort_stream #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_VALS  = 8,
  parameter int SIGNED    = 0,
  parameter int CNT_W     = $clog2(NUM_VALS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_desc,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic [CNT_W-1:0]     o_count
);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t               r_state;
  logic [SIZE_DATA-1:0] r_slot [NUM_VALS];
  logic [CNT_W-1:0]     r_count;
  logic                 r_desc;

  logic [NUM_VALS-1:0]  w_keep;
  logic [SIZE_DATA-1:0] w_ins [NUM_VALS];
  logic                 w_accept;
  logic                 w_end_fill;

  // True when held slot s must stay ahead of new element x (ties keep arrival order).
  function automatic logic keep_ahead(input logic [SIZE_DATA-1:0] s,
                                      input logic [SIZE_DATA-1:0] x,
                                      input logic                 desc);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(s) > $signed(x);
      lt = $signed(s) < $signed(x);
    end else begin
      gt = s > x;
      lt = s < x;
    end
    return desc ? !lt : !gt;
  endfunction

  // The array is sorted, so w_keep is a prefix; the first cleared bit is the insert point.
  always_comb begin
    w_keep = '0;
    for (int unsigned k = 0; k < NUM_VALS; k++) begin
      w_keep[k] = (CNT_W'(k) < r_count) && keep_ahead(r_slot[k], i_data, r_desc);
    end
    w_ins[0] = w_keep[0] ? r_slot[0] : i_data;
    for (int unsigned k = 1; k < NUM_VALS; k++) begin
      if (w_keep[k])
        w_ins[k] = r_slot[k];
      else if (w_keep[k-1])
        w_ins[k] = i_data;
      else
        w_ins[k] = r_slot[k-1];
    end
  end

  assign w_accept   = i_valid && (r_state == FILL);
  assign w_end_fill = i_last || (r_count == CNT_W'(NUM_VALS - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= FILL;
      r_count <= '0;
      r_desc  <= 1'b0;
      for (int unsigned k = 0; k < NUM_VALS; k++) r_slot[k] <= '0;
    end else if (i_clear) begin
      r_state <= FILL;
      r_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            for (int unsigned k = 0; k < NUM_VALS; k++) r_slot[k] <= w_ins[k];
            r_count <= r_count + CNT_W'(1);
            if (r_count == '0) r_desc <= i_desc;
            if (w_end_fill) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_ready) begin
            for (int unsigned k = 0; k < NUM_VALS - 1; k++) r_slot[k] <= r_slot[k+1];
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign o_ready = (r_state == FILL);
  assign o_valid = (r_state == DRAIN);
  assign o_data  = r_slot[0];
  assign o_last  = (r_state == DRAIN) && (r_count == CNT_W'(1));
  assign o_count = r_count;

endmodule

// File: tb/tb_insertion_sort_stream.sv
// Scoreboard bench: an unsigned and a signed sorter share one stimulus stream;
// expected drain order comes from a rank-based reference sort.
module tb_insertion_sort_stream;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       desc;
  logic       vld;
  logic [7:0] data;
  logic       last;
  logic       rdy;

  logic       ordy  [2];
  logic       ovld  [2];
  logic [7:0] odata [2];
  logic       olast [2];
  logic [3:0] ocnt  [2];

  insertion_sort_stream #(.SIZE_DATA(8), .NUM_VALS(8), .SIGNED(0)) u_dut_u (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_desc(desc), .i_valid(vld),
    .i_data(data), .i_last(last), .o_ready(ordy[0]), .o_valid(ovld[0]),
    .o_data(odata[0]), .o_last(olast[0]), .i_ready(rdy), .o_count(ocnt[0]));

  insertion_sort_stream #(.SIZE_DATA(8), .NUM_VALS(8), .SIGNED(1)) u_dut_s (
    .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_desc(desc), .i_valid(vld),
    .i_data(data), .i_last(last), .o_ready(ordy[1]), .o_valid(ovld[1]),
    .o_data(odata[1]), .o_last(olast[1]), .i_ready(rdy), .o_count(ocnt[1]));

  int         nchk = 0;
  int         nerr = 0;
  int         hs_cnt = 0;
  int         rmode = 0;
  logic [7:0] stim [8];
  logic [7:0] batch [$];
  bit         bdesc;
  logic [8:0] sb0 [$];
  logic [8:0] sb1 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int keyv(input logic [7:0] d, input bit sgn, input bit dsc);
    int k;
    k = sgn ? int'($signed(d)) : int'(d);
    return dsc ? -k : k;
  endfunction

  function automatic int rank_of(input int i, input bit sgn);
    int r;
    int ki;
    int kj;
    r  = 0;
    ki = keyv(batch[i], sgn, bdesc);
    for (int j = 0; j < batch.size(); j++) begin
      kj = keyv(batch[j], sgn, bdesc);
      if (kj < ki || (kj == ki && j < i)) r++;
    end
    return r;
  endfunction

  task automatic build_expected();
    int n;
    n = batch.size();
    for (int s = 0; s < 2; s++)
      for (int pos = 0; pos < n; pos++)
        for (int i = 0; i < n; i++)
          if (rank_of(i, s != 0) == pos) begin
            if (s == 0) sb0.push_back({pos == n - 1, batch[i]});
            else        sb1.push_back({pos == n - 1, batch[i]});
          end
  endtask

  // i_desc is driven to the opposite value after the first element to prove it is ignored.
  task automatic send(input int n, input bit dsc, input bit use_last, input bit fin);
    int t;
    batch.delete();
    bdesc = dsc;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!ordy[0] && t < 100) begin
        step();
        t++;
      end
      if (!ordy[0]) chk("ready_timeout", 32'(ordy[0]), 32'd1);
      vld  = 1'b1;
      data = stim[i];
      last = use_last && (i == n - 1);
      desc = (i == 0) ? dsc : !dsc;
      if (i == 0) chk("idle_valid", 32'(ovld[0]), 32'd0);
      step();
      batch.push_back(stim[i]);
    end
    vld  = 1'b0;
    last = 1'b0;
    if (fin) begin
      build_expected();
      chk("valid_latency_u", 32'(ovld[0]), 32'd1);
      chk("valid_latency_s", 32'(ovld[1]), 32'd1);
      chk("count_full", 32'(ocnt[0]), 32'(n));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && t < 300) begin
      step();
      t++;
    end
    chk("drain_timeout", 32'(sb0.size() + sb1.size()), 32'd0);
    chk("fill_ready", 32'(ordy[0]), 32'd1);
    chk("fill_valid", 32'(ovld[0]), 32'd0);
    chk("fill_count", 32'(ocnt[0]), 32'd0);
  endtask

  // Ready pattern generator: 0 always, 1 repeating 1,0,0, 2 random, 3 held low.
  initial begin
    int ph;
    ph  = 0;
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: rdy = 1'b1;
        1: begin
          rdy = (ph == 0);
          ph  = (ph == 2) ? 0 : ph + 1;
        end
        2: rdy = 1'($urandom_range(0, 1));
        default: rdy = 1'b0;
      endcase
    end
  end

  // Monitor: every valid cycle must show the scoreboard head; a handshake pops it.
  initial begin
    logic [8:0] e;
    int         sz;
    forever begin
      @(negedge clk);
      if (!rst && !clear) begin
        for (int d = 0; d < 2; d++) begin
          if (ovld[d]) begin
            sz = (d == 0) ? sb0.size() : sb1.size();
            if (sz == 0) begin
              nchk++;
              nerr++;
              $display("FAIL unexpected_out dut%0d: got %0h expected none", d, odata[d]);
            end else begin
              e = (d == 0) ? sb0[0] : sb1[0];
              chk($sformatf("data_dut%0d", d), 32'(odata[d]), 32'(e[7:0]));
              chk($sformatf("last_dut%0d", d), 32'(olast[d]), 32'(e[8]));
              if (rdy) begin
                if (d == 0) begin
                  void'(sb0.pop_front());
                  hs_cnt++;
                end else begin
                  void'(sb1.pop_front());
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; desc = 1'b0; vld = 1'b0; data = '0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ordy[0]), 32'd1);
    chk("rst_valid", 32'(ovld[0]), 32'd0);
    chk("rst_last",  32'(olast[0]), 32'd0);
    chk("rst_data",  32'(odata[0]), 32'd0);
    chk("rst_count", 32'(ocnt[0]), 32'd0);
    rst = 1'b0;
    step();

    // ascending full batch, no i_last
    stim = '{8'd12, 8'd5, 8'd1, 8'd20, 8'd3, 8'd15, 8'd29, 8'd1};
    send(8, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // descending partial batch
    stim = '{8'd7, 8'd42, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(3, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // signed vs unsigned ordering
    stim = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'd0, 8'd0, 8'd0, 8'd0};
    send(4, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // back-pressure on the full batch
    rmode  = 1;
    hs_cnt = 0;
    stim = '{8'd12, 8'd5, 8'd1, 8'd20, 8'd3, 8'd15, 8'd29, 8'd1};
    send(8, 1'b0, 1'b0, 1'b1);
    wait_drain();
    chk("handshakes", 32'(hs_cnt), 32'd8);
    rmode = 0;

    // abort after three accepts, then a fresh batch
    stim = '{8'd50, 8'd60, 8'd70, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(3, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_count", 32'(ocnt[0]), 32'd0);
    chk("clear_valid", 32'(ovld[0]), 32'd0);
    stim = '{8'd4, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(2, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // async reset while draining
    rmode = 3;
    stim = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    send(4, 1'b0, 1'b1, 1'b1);
    step();
    chk("stall_valid", 32'(ovld[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ovld[0]), 32'd0);
    chk("arst_ready", 32'(ordy[0]), 32'd1);
    chk("arst_count", 32'(ocnt[0]), 32'd0);
    sb0.delete();
    sb1.delete();
    step();
    rst   = 1'b0;
    rmode = 0;
    step();

    // equal keys, then a back-to-back batch
    stim = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0};
    send(4, 1'b0, 1'b1, 1'b1);
    wait_drain();
    stim = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send(3, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // randomized batches
    rmode = 2;
    for (int b = 0; b < 30; b++) begin
      int n;
      bit ul;
      n  = int'($urandom_range(1, 8));
      ul = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++)
        stim[i] = (b % 2 == 0) ? 8'($urandom) : 8'($urandom_range(250, 260) % 256);
      send(n, 1'($urandom_range(0, 1)), ul, 1'b1);
      wait_drain();
    end
    rmode = 0;

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
